shift_add_mult_4bit: RTL and testbench



---
 rtl/shift_add_mult_4bit_pkg.sv | 21 ++
 rtl/four_bit_adder.sv | 28 ++
 rtl/shift_add_mult_4bit_ctrl.sv | 87 ++++++++
 rtl/shift_add_mult_4bit.sv | 92 +++++++++
 tb/tb_shift_add_mult_4bit.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/shift_add_mult_4bit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : shift_add_mult_4bit_pkg
//  Description : Shared state encodings and widths for the shift-add
//                4x4 multiplier and its control FSM.
//  Revision    : 1.0 - initial release
// ============================================================================
package shift_add_mult_4bit_pkg;

  localparam int WIDTH  = 4;
  localparam int PROD_W = 8;

  // Two-bit encoding; 2'b11 is unused and decodes back to idle.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage : shift_add_mult_4bit_pkg
`default_nettype wire

// File: rtl/four_bit_adder.sv
`default_nettype none
// ============================================================================
//  Module      : four_bit_adder
//  Description : Combinational 4-bit ripple-carry adder cell.
//  Revision    : 1.0 - initial release
// ============================================================================
module four_bit_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] w_carry;

  assign w_carry[0] = cin;

  // One full-adder stage per bit, carry rippling upward.
  for (genvar i = 0; i < 4; i++) begin : g_bit
    assign sum[i]       = a[i] ^ b[i] ^ w_carry[i];
    assign w_carry[i+1] = (a[i] & b[i]) | (w_carry[i] & (a[i] ^ b[i]));
  end

  assign cout = w_carry[4];

endmodule : four_bit_adder
`default_nettype wire

// File: rtl/shift_add_mult_4bit_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mult_ctrl_fsm
//  Description : IDLE/RUN/DONE sequencer for the shift-add multiplier.
//                Owns the iteration counter and the busy/done handshake,
//                and strobes the datapath with load/step/last.
//  Revision    : 1.0 - initial release
// ============================================================================
module mult_ctrl_fsm
  import shift_add_mult_4bit_pkg::*;
#(
  parameter int CNT_W = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic busy,
  output logic done,
  output logic load,
  output logic step,
  output logic last
);

  localparam logic [CNT_W-1:0] c_last_cnt = '1;

  state_t             r_state;
  state_t             w_next;
  logic   [CNT_W-1:0] r_cnt;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and strobes; start is only honoured outside RUN.
  always_comb begin
    w_next = ST_IDLE;
    busy   = 1'b0;
    done   = 1'b0;
    load   = 1'b0;
    step   = 1'b0;
    last   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          load   = 1'b1;
          w_next = ST_RUN;
        end
      end
      ST_RUN: begin
        busy = 1'b1;
        step = 1'b1;
        if (r_cnt == c_last_cnt) begin
          last   = 1'b1;
          w_next = ST_DONE;
        end else begin
          w_next = ST_RUN;
        end
      end
      ST_DONE: begin
        done = 1'b1;
        if (start) begin
          load   = 1'b1;
          w_next = ST_RUN;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Iteration counter: cleared on accept, advanced once per RUN step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= '0;
    end else if (step) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule : mult_ctrl_fsm
`default_nettype wire

// File: rtl/shift_add_mult_4bit.sv
`default_nettype none
// ============================================================================
//  Module      : shift_add_mult_4bit
//  Description : Sequential unsigned 4x4 shift-add multiplier. One add and
//                9-bit right shift per clock; 8-bit product after 4 steps.
//  Revision    : 1.0 - initial release
// ============================================================================
module shift_add_mult_4bit #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  import shift_add_mult_4bit_pkg::*;

  // The adder cell is fixed at 4 bits, so nothing else can be built.
  if (WIDTH != 4 || CNT_W != 2) begin : g_param_check
    $fatal(1, "shift_add_mult_4bit: only WIDTH=4, CNT_W=2 is supported");
  end

  logic [WIDTH-1:0]  r_m;
  logic [WIDTH-1:0]  r_acc;
  logic [WIDTH-1:0]  r_q;
  logic [PROD_W-1:0] r_product;

  logic              w_load;
  logic              w_step;
  logic              w_last;
  logic [WIDTH-1:0]  w_addend;
  logic [WIDTH-1:0]  w_sum;
  logic              w_cout;
  logic [PROD_W-1:0] w_shifted;

  mult_ctrl_fsm #(
    .CNT_W (CNT_W)
  ) u_ctrl (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .busy  (busy),
    .done  (done),
    .load  (w_load),
    .step  (w_step),
    .last  (w_last)
  );

  // Partial product is the multiplicand gated by the current multiplier LSB.
  assign w_addend = {WIDTH{r_q[0]}} & r_m;

  four_bit_adder u_adder (
    .a    (r_acc),
    .b    (w_addend),
    .cin  (1'b0),
    .sum  (w_sum),
    .cout (w_cout)
  );

  // {c,sum,q} shifted right by one; carry lands in acc[3].
  assign w_shifted = {w_cout, w_sum, r_q[WIDTH-1:1]};

  // Datapath: capture operands on accept, shift-add while running,
  // publish the product on the final step only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m       <= '0;
      r_acc     <= '0;
      r_q       <= '0;
      r_product <= '0;
    end else if (w_load) begin
      r_m   <= a;
      r_q   <= b;
      r_acc <= '0;
    end else if (w_step) begin
      {r_acc, r_q} <= w_shifted;
      if (w_last) begin
        r_product <= w_shifted;
      end
    end
  end

  assign product = r_product;

endmodule : shift_add_mult_4bit
`default_nettype wire

// File: tb/tb_shift_add_mult_4bit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shift_add_mult_4bit
//  Description : Self-checking bench for the shift-add 4x4 multiplier.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_add_mult_4bit;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic       busy;
  logic       done;
  logic [7:0] product;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[8];
  logic [7:0] prev_product;

  shift_add_mult_4bit #(
    .WIDTH (4),
    .CNT_W (2)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Single operation from idle: checks handshake timing and product hold.
  task automatic run_op(input logic [3:0] va, input logic [3:0] vb, input logic [7:0] exp);
    a = va;
    b = vb;
    start = 1'b1;
    tick();                           // accepting edge
    start = 1'b0;
    a = ~va;                          // operands are don't-care from here on
    b = ~vb;
    check("op_busy_c1", {busy, done}, 2'b10);
    check("op_prod_kept", product, prev_product);
    for (int s = 0; s < 3; s++) begin
      tick();
      check("op_busy_run", {busy, done}, 2'b10);
    end
    tick();
    check("op_done", {busy, done}, 2'b01);
    check("op_product", product, exp);
    tick();
    check("op_idle_after", {busy, done}, 2'b00);
    check("op_product_hold", product, exp);
    prev_product = exp;
  endtask

  initial begin
    int done_cnt;
    int busy_cnt;
    int bad_proto;
    logic [3:0] ea;
    logic [3:0] eb;

    vecs[0] = '{4'hF, 4'hF, 8'hE1};
    vecs[1] = '{4'h7, 4'h9, 8'h3F};
    vecs[2] = '{4'h0, 4'hD, 8'h00};
    vecs[3] = '{4'h1, 4'h1, 8'h01};
    vecs[4] = '{4'hF, 4'h1, 8'h0F};
    vecs[5] = '{4'h8, 4'hF, 8'h78};
    vecs[6] = '{4'hD, 4'h0, 8'h00};
    vecs[7] = '{4'hA, 4'hC, 8'h78};

    rst_n = 1'b0;
    start = 1'b0;
    a = 4'h0;
    b = 4'h0;
    prev_product = 8'h00;

    // Reset state.
    #1;
    check("reset_outputs", {busy, done, product}, 10'h000);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("reset_idle", {busy, done, product}, 10'h000);

    // Table-driven operations from idle.
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].exp);
    end

    // Start pulses and operand churn during RUN are ignored.
    a = 4'h7;
    b = 4'h9;
    start = 1'b1;
    tick();
    busy_cnt = busy ? 1 : 0;
    done_cnt = done ? 1 : 0;
    for (int k = 0; k < 11; k++) begin
      if (k < 3) begin
        start = 1'b1;
        a = k[0] ? 4'hC : 4'h3;
        b = k[0] ? 4'hC : 4'h3;
      end else begin
        start = 1'b0;
      end
      tick();
      if (busy) busy_cnt++;
      if (done) done_cnt++;
    end
    check("ign_busy_width", busy_cnt, 4);
    check("ign_done_count", done_cnt, 1);
    check("ign_product", product, 8'h3F);

    // Start held high: re-accepted in each DONE cycle, done every 5 cycles.
    a = 4'h5;
    b = 4'h6;
    start = 1'b1;
    tick();
    check("b2b_first_busy", {busy, done}, 2'b10);
    for (int r = 0; r < 3; r++) begin
      tick();
      tick();
      tick();
      check("b2b_pre_done", {busy, done}, 2'b10);
      tick();
      check("b2b_done", {busy, done}, 2'b01);
      check("b2b_product", product, 8'h1E);
      tick();
      check("b2b_reaccept", {busy, done}, 2'b10);
    end
    start = 1'b0;
    for (int s = 0; s < 3; s++) tick();
    tick();
    check("b2b_last_done", {busy, done, product}, {2'b01, 8'h1E});
    tick();

    // Asynchronous reset in the second RUN cycle of 15*15.
    a = 4'hF;
    b = 4'hF;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_outputs", {busy, done, product}, 10'h000);
    #2 rst_n = 1'b1;
    busy_cnt = 0;
    done_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (busy) busy_cnt++;
      if (done) done_cnt++;
    end
    check("post_rst_no_done", done_cnt, 0);
    check("post_rst_no_busy", busy_cnt, 0);
    prev_product = 8'h00;
    run_op(4'h2, 4'h3, 8'h06);

    // Exhaustive back-to-back sweep over all operand pairs.
    bad_proto = 0;
    a = 4'h0;
    b = 4'h0;
    start = 1'b1;
    for (int i = 0; i < 256; i++) begin
      ea = i[7:4];
      eb = i[3:0];
      a = ea;
      b = eb;
      tick();                         // accepting edge
      a = ~ea;
      b = ~eb;
      if (i == 255) start = 1'b0;
      busy_cnt = busy ? 1 : 0;
      if (done) bad_proto++;
      for (int s = 0; s < 3; s++) begin
        tick();
        if (busy) busy_cnt++;
        if (busy && done) bad_proto++;
      end
      tick();
      if (busy) bad_proto++;
      check("exh_product", product, {4'h0, ea} * {4'h0, eb});
      check("exh_proto", {busy_cnt[2:0], done}, {3'd4, 1'b1});
    end
    check("exh_overlap", bad_proto, 0);
    tick();
    check("exh_idle", {busy, done}, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule : tb_shift_add_mult_4bit
`default_nettype wire
